// File: rtl/nd_loop_issuer_if.sv
// Config and index channels of the ND loop-index issuer.
// Latency: n/a (signal bundle only).
// Backpressure: cfg_rdy/cfg_ack and idx_rdy/idx_ack valid-ready pairs.
interface nd_loop_issuer_if #(
  parameter int BW  = 8,
  parameter int DIM = 2
);
  // configuration channel: rdy = valid from upstream, ack = accept from issuer
  logic                    cfg_rdy;
  logic                    cfg_ack;
  logic [DIM-1:0][BW-1:0]  beg;
  logic [DIM-1:0][BW-1:0]  stride;
  logic [DIM-1:0][BW-1:0]  end_idx;   // exclusive bound, equality compare

  // index channel: rdy = valid from issuer, ack = accept from downstream
  logic                    idx_rdy;
  logic                    idx_ack;
  logic [DIM-1:0][BW-1:0]  idx;
  logic [DIM-1:0][BW-1:0]  idx_noofs;
  logic [DIM:0]            sel_ret;
  logic                    last;

  // upstream / downstream side (drives config, consumes indices)
  modport master (
    output cfg_rdy, beg, stride, end_idx, idx_ack,
    input  cfg_ack, idx_rdy, idx, idx_noofs, sel_ret, last
  );

  // issuer side
  modport slave (
    input  cfg_rdy, beg, stride, end_idx, idx_ack,
    output cfg_ack, idx_rdy, idx, idx_noofs, sel_ret, last
  );
endinterface

// File: rtl/nd_loop_issuer.sv
// Walks an N-dim loop nest (dim DIM-1 innermost), one index vector per beat, with one-hot retire selector.
// Latency: first index the cycle after cfg accept; one index per cycle; one idle bubble between loops.
// Backpressure: index/offset/selector held while idx_rdy && !idx_ack; cfg accepted only when idle.
module nd_loop_issuer #(
  parameter int BW  = 8,
  parameter int DIM = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  nd_loop_issuer_if.slave  io
);

  typedef logic [DIM-1:0][BW-1:0] vec_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t       state_q;
  state_t       state_d;

  // latched loop configuration
  vec_t         beg_q;
  vec_t         stride_q;
  vec_t         end_q;

  // live loop position and its begin-relative offset
  vec_t         cur_q;
  vec_t         noofs_q;
  vec_t         cur_d;
  vec_t         noofs_d;

  vec_t         added;
  logic [DIM-1:0] wrap;
  // wrap_run[j]: the j innermost dimensions all wrap on this advance
  logic [DIM:0] wrap_run;
  logic [DIM:0] sel;

  logic         cfg_xfer;
  logic         idx_xfer;
  logic         cfg_empty;

  assign cfg_xfer = io.cfg_rdy && (state_q == IDLE);
  assign idx_xfer = io.idx_ack && (state_q == RUN);

  // per-dimension candidate next value and wrap detect (equality against bound)
  always_comb begin
    added = '0;
    wrap  = '0;
    for (int d = 0; d < DIM; d++) begin
      added[d] = cur_q[d] + stride_q[d];
      wrap[d]  = (added[d] == end_q[d]);
    end
  end

  // count consecutive wrapping dimensions from innermost out, as a one-hot
  always_comb begin
    wrap_run    = '0;
    sel         = '0;
    wrap_run[0] = 1'b1;
    for (int j = 0; j < DIM; j++) begin
      wrap_run[j+1] = wrap_run[j] & wrap[DIM-1-j];
    end
    for (int j = 0; j < DIM; j++) begin
      sel[j] = wrap_run[j] & ~wrap_run[j+1];
    end
    sel[DIM] = wrap_run[DIM];
  end

  // an incoming config with any zero-trip dimension produces no beats
  always_comb begin
    cfg_empty = 1'b0;
    for (int d = 0; d < DIM; d++) begin
      if (io.beg[d] == io.end_idx[d]) begin
        cfg_empty = 1'b1;
      end
    end
  end

  // next-state: idle until a non-empty config lands, run until the last beat leaves
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cfg_xfer && !cfg_empty) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (idx_xfer && sel[DIM]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // next loop position: carry dim advances, inner dims restart, outer dims hold
  always_comb begin
    cur_d   = cur_q;
    noofs_d = noofs_q;
    if (cfg_xfer) begin
      cur_d   = io.beg;
      noofs_d = '0;
    end else if (idx_xfer) begin
      for (int d = 0; d < DIM; d++) begin
        if (sel[DIM-1-d]) begin
          cur_d[d]   = added[d];
          noofs_d[d] = noofs_q[d] + stride_q[d];
        end else if (wrap_run[DIM-d]) begin
          cur_d[d]   = beg_q[d];
          noofs_d[d] = '0;
        end
      end
    end
  end

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // position registers; config captured only on the accept cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cur_q    <= '0;
      noofs_q  <= '0;
      beg_q    <= '0;
      stride_q <= '0;
      end_q    <= '0;
    end else begin
      cur_q   <= cur_d;
      noofs_q <= noofs_d;
      if (cfg_xfer) begin
        beg_q    <= io.beg;
        stride_q <= io.stride;
        end_q    <= io.end_idx;
      end
    end
  end

  // all outputs come from registered state only
  assign io.cfg_ack   = (state_q == IDLE);
  assign io.idx_rdy   = (state_q == RUN);
  assign io.idx       = cur_q;
  assign io.idx_noofs = noofs_q;
  assign io.sel_ret   = sel;
  assign io.last      = sel[DIM];

  a_sel_onehot: assert property (@(posedge i_clk) disable iff (i_rst)
    io.idx_rdy |-> $onehot(io.sel_ret));

  a_hold: assert property (@(posedge i_clk) disable iff (i_rst)
    (io.idx_rdy && !io.idx_ack) |=> (io.idx_rdy && $stable(io.idx) && $stable(io.idx_noofs)));

endmodule
